code_decoder: RTL and testbench



---
 rtl/code_decoder_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 24 ++
 rtl/code_decoder.sv | 148 ++++++++++++++
 tb/tb_code_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/code_decoder_pkg.sv
// Shared types and 7-segment constants for the switch-code decoder and its encoder twin.
package code_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Active-low segments, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit digit to active-low 7-segment pattern (g..a).
module seg7_decode
    import code_decoder_pkg::*;
(
    input  logic [2:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            3'd0: seg_o = SEG_0;
            3'd1: seg_o = SEG_1;
            3'd2: seg_o = SEG_2;
            3'd3: seg_o = SEG_3;
            3'd4: seg_o = SEG_4;
            3'd5: seg_o = SEG_5;
            3'd6: seg_o = SEG_6;
            3'd7: seg_o = SEG_7;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/code_decoder.sv
// Debounced 3-to-8 decoder driving LED bar, valid LED, acceptance counter and HEX0.
// HEX0 segment logic is built only when CODE_DECODER_HEX_EN is defined.
module code_decoder
    import code_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code,
    input  logic             enable,
    output logic [7:0]       onehot,
    output logic             valid,
    output logic             strobe,
    output logic [CNT_W-1:0] update_cnt,
    output logic [6:0]       HEX0
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       cand_q, cand_d;
    logic [DB_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [2:0]       held_q, held_d;
    logic [7:0]       onehot_q, onehot_d;
    logic             valid_q, valid_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] upd_q, upd_d;

    logic       load;
    logic       accept;
    logic       counted;
    logic [2:0] acc_code;

    assign cnt_inc = cnt_q + DB_W'(1);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        accept   = 1'b0;
        acc_code = cand_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE:   load = 1'b1;
                SETTLE: begin
                    if (code != cand_q) begin
                        load = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_LAST) accept = 1'b1;
                    end
                end
                HOLD:   if (code != held_q) load = 1'b1;
                default: state_d = IDLE;
            endcase
            // The loading edge is the first sample, so D=1 accepts right here.
            if (load) begin
                cand_d   = code;
                cnt_d    = DB_W'(1);
                state_d  = SETTLE;
                acc_code = code;
                if (DEBOUNCE_CYCLES == 1) accept = 1'b1;
            end
            if (accept) state_d = HOLD;
        end
    end

    // Re-accepting the code already on display is silent.
    assign counted = accept && (!valid_q || (acc_code != held_q));

    always_comb begin
        onehot_d = onehot_q;
        valid_d  = valid_q;
        held_d   = held_q;
        strobe_d = 1'b0;
        upd_d    = upd_q;
        if (!enable) begin
            onehot_d = '0;
            valid_d  = 1'b0;
        end else if (counted) begin
            onehot_d = 8'(1) << acc_code;
            valid_d  = 1'b1;
            held_d   = acc_code;
            strobe_d = 1'b1;
            upd_d    = upd_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            held_q   <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            upd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            upd_q    <= upd_d;
        end
    end

    assign onehot     = onehot_q;
    assign valid      = valid_q;
    assign strobe     = strobe_q;
    assign update_cnt = upd_q;

`ifdef CODE_DECODER_HEX_EN
    logic [6:0] seg_acc;
    logic [6:0] hex_q, hex_d;

    seg7_decode u_seg7 (
        .digit_i (acc_code),
        .seg_o   (seg_acc)
    );

    always_comb begin
        hex_d = hex_q;
        if (!enable)      hex_d = SEG_BLANK;
        else if (counted) hex_d = seg_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hex_q <= SEG_BLANK;
        else     hex_q <= hex_d;
    end

    assign HEX0 = hex_q;
`else
    assign HEX0 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_code_decoder.sv
// Directed bench for code_decoder with DEBOUNCE_CYCLES=4, CNT_W=8.
module tb_code_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code;
    logic       enable;
    logic [7:0] onehot;
    logic       valid;
    logic       strobe;
    logic [7:0] update_cnt;
    logic [6:0] HEX0;

    int tests = 0;
    int fails = 0;
    int scount;

    always #5 clk = ~clk;

    code_decoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .enable     (enable),
        .onehot     (onehot),
        .valid      (valid),
        .strobe     (strobe),
        .update_cnt (update_cnt),
        .HEX0       (HEX0)
    );

    function automatic logic [6:0] hexx(input int d);
`ifdef CODE_DECODER_HEX_EN
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            default: return 7'b1111111;
        endcase
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        code   = 3'd0;
        #2;
        chk("rst_onehot", 32'(onehot), 32'h00);
        chk("rst_valid",  32'(valid), 32'd0);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_cnt",    32'(update_cnt), 32'd0);
        chk("rst_hex",    32'(HEX0), 32'h7f);
        step();
        step();
        rst = 1'b0;

        // basic accept of 5, latency D-1 edges after first sample
        enable = 1'b1;
        code   = 3'd5;
        step();
        chk("acc5_e1_valid", 32'(valid), 32'd0);
        step();
        step();
        chk("acc5_e3_valid", 32'(valid), 32'd0);
        chk("acc5_e3_strobe", 32'(strobe), 32'd0);
        step();
        chk("acc5_onehot", 32'(onehot), 32'h20);
        chk("acc5_valid",  32'(valid), 32'd1);
        chk("acc5_strobe", 32'(strobe), 32'd1);
        chk("acc5_cnt",    32'(update_cnt), 32'd1);
        chk("acc5_hex",    32'(HEX0), 32'(hexx(5)));
        step();
        chk("acc5_strobe_off", 32'(strobe), 32'd0);

        // accept 3, then glitch to 6 for two cycles and back
        code = 3'd3;
        for (int i = 0; i < 3; i++) step();
        chk("acc3_pre_onehot", 32'(onehot), 32'h20);
        step();
        chk("acc3_onehot", 32'(onehot), 32'h08);
        chk("acc3_cnt",    32'(update_cnt), 32'd2);
        chk("acc3_strobe", 32'(strobe), 32'd1);
        code = 3'd6;
        scount = 0;
        step(); scount += int'(strobe);
        step(); scount += int'(strobe);
        chk("glitch_mid_onehot", 32'(onehot), 32'h08);
        code = 3'd3;
        for (int i = 0; i < 6; i++) begin
            step();
            scount += int'(strobe);
        end
        chk("glitch_onehot",  32'(onehot), 32'h08);
        chk("glitch_valid",   32'(valid), 32'd1);
        chk("glitch_strobes", 32'(scount), 32'd0);
        chk("glitch_cnt",     32'(update_cnt), 32'd2);
        chk("glitch_hex",     32'(HEX0), 32'(hexx(3)));

        // change from 3 to 7
        code = 3'd7;
        for (int i = 0; i < 3; i++) step();
        chk("chg7_pre_onehot", 32'(onehot), 32'h08);
        step();
        chk("chg7_onehot", 32'(onehot), 32'h80);
        chk("chg7_hex",    32'(HEX0), 32'(hexx(7)));
        chk("chg7_cnt",    32'(update_cnt), 32'd3);
        chk("chg7_strobe", 32'(strobe), 32'd1);

        // disable while holding
        enable = 1'b0;
        step();
        chk("dis_onehot", 32'(onehot), 32'h00);
        chk("dis_valid",  32'(valid), 32'd0);
        chk("dis_hex",    32'(HEX0), 32'h7f);
        chk("dis_cnt",    32'(update_cnt), 32'd3);
        chk("dis_strobe", 32'(strobe), 32'd0);

        // re-enable with code 0
        enable = 1'b1;
        code   = 3'd0;
        for (int i = 0; i < 3; i++) step();
        chk("re0_pre_valid", 32'(valid), 32'd0);
        step();
        chk("re0_onehot", 32'(onehot), 32'h01);
        chk("re0_valid",  32'(valid), 32'd1);
        chk("re0_hex",    32'(HEX0), 32'(hexx(0)));
        chk("re0_cnt",    32'(update_cnt), 32'd4);

        // disable on the very edge that would accept code 2
        code = 3'd2;
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        step();
        chk("disacc_valid",  32'(valid), 32'd0);
        chk("disacc_strobe", 32'(strobe), 32'd0);
        chk("disacc_onehot", 32'(onehot), 32'h00);
        chk("disacc_cnt",    32'(update_cnt), 32'd4);

        // reset in the middle of a debounce
        enable = 1'b1;
        code   = 3'd6;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_cnt",    32'(update_cnt), 32'd0);
        chk("midrst_valid",  32'(valid), 32'd0);
        chk("midrst_onehot", 32'(onehot), 32'h00);
        chk("midrst_hex",    32'(HEX0), 32'h7f);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("midrst_pre_valid", 32'(valid), 32'd0);
        step();
        chk("midrst_acc_onehot", 32'(onehot), 32'h40);
        chk("midrst_acc_cnt",    32'(update_cnt), 32'd1);

        // counter wrap: 256 alternating accepts of 1 and 2
        rst = 1'b1;
        step();
        rst = 1'b0;
        scount = 0;
        for (int n = 0; n < 256; n++) begin
            code = (n % 2 == 0) ? 3'd1 : 3'd2;
            for (int k = 0; k < 4; k++) begin
                step();
                scount += int'(strobe);
            end
            if (n == 254) chk("wrap_cnt_255", 32'(update_cnt), 32'd255);
        end
        chk("wrap_cnt",     32'(update_cnt), 32'd0);
        chk("wrap_strobes", 32'(scount), 32'd256);
        chk("wrap_onehot",  32'(onehot), 32'h04);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
